// File: rtl/carregador_programa.sv
// Program loader: accepts a stream of bytes over a valid/ready handshake and
// writes them to consecutive program-memory addresses starting at a captured base.
module carregador_programa #(
  parameter int unsigned LARG_END  = 9,
  parameter int unsigned LARG_DADO = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [LARG_END-1:0]  base,
  input  logic [LARG_END-1:0]  quantidade,
  input  logic [LARG_DADO-1:0] dado_in,
  input  logic                 valido_in,
  output logic                 pronto_out,
  output logic [LARG_END-1:0]  mem_end,
  output logic [LARG_DADO-1:0] mem_dado,
  output logic                 mem_we,
  output logic                 ocupado,
  output logic                 fim,
  output logic [LARG_END-1:0]  contagem,
  output logic [LARG_DADO-1:0] soma
);

  typedef enum logic [0:0] {StOcioso, StCarrega} estado_e;

  estado_e              estado_q, estado_d;
  logic [LARG_END-1:0]  base_q, base_d;
  logic [LARG_END-1:0]  quant_q, quant_d;
  logic [LARG_END-1:0]  contagem_q, contagem_d;
  logic [LARG_DADO-1:0] soma_q, soma_d;
  logic [LARG_END-1:0]  mem_end_q, mem_end_d;
  logic [LARG_DADO-1:0] mem_dado_q, mem_dado_d;
  logic                 mem_we_q, mem_we_d;
  logic                 fim_q, fim_d;

  logic                 aceita;
  logic [LARG_END-1:0]  contagem_inc;

  assign aceita       = (estado_q == StCarrega) && valido_in;
  assign contagem_inc = contagem_q + LARG_END'(1);

  always_comb begin
    estado_d   = estado_q;
    base_d     = base_q;
    quant_d    = quant_q;
    contagem_d = contagem_q;
    soma_d     = soma_q;
    mem_end_d  = mem_end_q;
    mem_dado_d = mem_dado_q;
    mem_we_d   = 1'b0;
    fim_d      = 1'b0;

    unique case (estado_q)
      StOcioso: begin
        if (inicio) begin
          base_d     = base;
          quant_d    = quantidade;
          contagem_d = '0;
          soma_d     = '0;
          if (quantidade == '0) begin
            fim_d = 1'b1;
          end else begin
            estado_d = StCarrega;
          end
        end
      end
      StCarrega: begin
        if (aceita) begin
          // contagem equals the bytes accepted so far, so it doubles as the address offset
          mem_we_d   = 1'b1;
          mem_dado_d = dado_in;
          mem_end_d  = base_q + contagem_q;
          contagem_d = contagem_inc;
          soma_d     = soma_q + dado_in;
          if (contagem_inc == quant_q) begin
            fim_d    = 1'b1;
            estado_d = StOcioso;
          end
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= StOcioso;
      base_q     <= '0;
      quant_q    <= '0;
      contagem_q <= '0;
      soma_q     <= '0;
      mem_end_q  <= '0;
      mem_dado_q <= '0;
      mem_we_q   <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      base_q     <= base_d;
      quant_q    <= quant_d;
      contagem_q <= contagem_d;
      soma_q     <= soma_d;
      mem_end_q  <= mem_end_d;
      mem_dado_q <= mem_dado_d;
      mem_we_q   <= mem_we_d;
      fim_q      <= fim_d;
    end
  end

  assign pronto_out = (estado_q == StCarrega);
  assign ocupado    = (estado_q == StCarrega);
  assign mem_end    = mem_end_q;
  assign mem_dado   = mem_dado_q;
  assign mem_we     = mem_we_q;
  assign fim        = fim_q;
  assign contagem   = contagem_q;
  assign soma       = soma_q;

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 SHALL have parameter LARG_END, default 9, the program-memory address width (512 words).
REQ-002 SHALL have parameter LARG_DADO, default 8, the program-memory data width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port inicio  input  1  start-load strobe; sampled only in OCIOSO.
REQ-006 SHALL have port base  input  LARG_END  first write address, captured on an accepted inicio.
REQ-007 SHALL have port quantidade  input  LARG_END  number of bytes to load, captured on an accepted inicio.
REQ-008 SHALL have port dado_in  input  LARG_DADO  incoming program byte.
REQ-009 SHALL have port valido_in  input  1  dado_in is valid.
REQ-010 SHALL have port pronto_out  output  1  block can accept a byte this cycle.
REQ-011 SHALL have port mem_end  output  LARG_END  program-memory write address.
REQ-012 SHALL have port mem_dado  output  LARG_DADO  program-memory write data.
REQ-013 SHALL have port mem_we  output  1  program-memory write enable, one cycle per byte.
REQ-014 SHALL have port ocupado  output  1  a load is in progress.
REQ-015 SHALL have port fim  output  1  single-cycle pulse when a load completes.
REQ-016 SHALL have port contagem  output  LARG_END  bytes written in the current or last load.
REQ-017 SHALL have port soma  output  LARG_DADO  modulo-2^LARG_DADO sum of bytes written in the current or last load.

Function
REQ-018 SHALL implement the states OCIOSO and CARREGA, encoded in a state register.
REQ-019 SHALL treat inicio as accepted in OCIOSO only: it captures base and quantidade, clears contagem and soma, and moves to CARREGA, or to OCIOSO with fim pulse if quantidade = 0.
REQ-020 SHALL ignore inicio while in CARREGA, with no restart and no change to captured base or quantidade.
REQ-021 SHALL drive pronto_out = 1 exactly when in CARREGA; a byte is accepted in a cycle with valido_in = 1 and pronto_out = 1.
REQ-022 SHALL drive, in the cycle after an accepted byte, mem_we = 1, mem_dado = that byte, and mem_end = (base + bytes accepted before it) mod 2^LARG_END.
REQ-023 SHALL drive mem_we = 0 in every other cycle; mem_end and mem_dado SHALL hold their last values when mem_we = 0.
REQ-024 SHALL wrap the address from 2^LARG_END-1 to 0 with no error indication.
REQ-025 SHALL increment contagem and add the byte to soma (carry discarded) in the same cycle its mem_we is asserted.
REQ-026 SHALL, in the cycle after the byte that makes the accepted count equal quantidade, assert fim for one cycle along with that byte's mem_we, and SHALL already be in OCIOSO in that cycle.
REQ-027 SHALL, for quantidade = 0, pulse fim in the cycle after inicio with no mem_we, and with contagem = 0 and soma = 0.
REQ-028 SHALL drive ocupado = 1 exactly when in CARREGA.
REQ-029 SHALL accept a new inicio in the same cycle fim is high; the new load starts normally.
REQ-030 SHALL never accept more than quantidade bytes per load; valido_in in OCIOSO is ignored.

Reset
REQ-031 SHALL, when reset = 1 at a clock edge, enter OCIOSO and drive pronto_out = 0, mem_we = 0, ocupado = 0, fim = 0, mem_end = 0, mem_dado = 0, contagem = 0, soma = 0.
REQ-032 SHALL, on reset during CARREGA, abandon the load, with no mem_we and no fim in the following cycle.
REQ-033 SHALL give reset priority over inicio and valido_in in the same cycle.

Verification
REQ-034 Basic load: base = 0x000, quantidade = 3, bytes 0x05, 0x02, 0x01 back-to-back -> writes at addresses 0, 1, 2 with those bytes; fim pulses with the 3rd write; contagem = 3; soma = 0x08.
REQ-035 Gapped handshake: quantidade = 2, valido_in toggled 1, 0, 0, 1 -> exactly 2 writes, one cycle after each accepted byte; pronto_out = 1 throughout the gap.
REQ-036 Wrap: base = 0x1FF, quantidade = 2, bytes 0xFF, 0x02 -> writes at 0x1FF then 0x000; soma = 0x01.
REQ-037 Zero length: quantidade = 0 -> fim is high one cycle after inicio; mem_we is never asserted; ocupado stays 0.
REQ-038 Reset mid-load: quantidade = 4, reset after 2 accepted bytes -> 2 writes only, no fim; all outputs at reset values in the next cycle; a new inicio is accepted afterwards.
REQ-039 Ignored restart: inicio with base = 0x100 pulsed during a load at base = 0x010 -> addresses continue from 0x010; the load length is unchanged.
